seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment display decoder; SEG_PAIR_VALUE_EN adds val_a/val_b
module seg_scan_decoder #(
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic [5:0] scan,
  input  logic [7:0] dout,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_vld,
  output logic       frame_done,
  output logic       scan_err,
  output logic       code_err,
  output logic       seq_err,
`ifdef SEG_PAIR_VALUE_EN
  output logic [6:0] val_a,
  output logic [6:0] val_b,
`endif
  output logic       stale
);

  localparam logic [1:0] ST_WAIT0 = 2'd0;
  localparam logic [1:0] ST_SEEN0 = 2'd1;
  localparam logic [1:0] ST_SEEN1 = 2'd2;
  localparam logic [1:0] ST_SEEN2 = 2'd3;

  localparam logic [1:0] STABLE_L  = 2'(STABLE_CNT);
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  logic [5:0]      scan_q;
  logic [7:0]      dout_q;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0][3:0] last_q, last_d;
  logic [3:0][1:0] cnt_q, cnt_d;
  logic [3:0]      vld_q, vld_d;
  logic [1:0]      state_q, state_d;
  logic [7:0]      idle_q, idle_d;
  logic            stale_q, stale_d;
  logic            frame_q, frame_d;
  logic            scan_err_q, scan_err_d;
  logic            code_err_q, code_err_d;
  logic            seq_err_q, seq_err_d;

  logic            slot_legal;
  logic [1:0]      slot;
  logic            scan_bad;
  logic            code_ok;
  logic [3:0]      code_val;
  logic [1:0]      next_cnt;

  always_comb begin
    slot_legal = 1'b1;
    slot       = 2'd0;
    case (scan_q)
      6'b000001: slot = 2'd0;
      6'b000010: slot = 2'd1;
      6'b010000: slot = 2'd2;
      6'b100000: slot = 2'd3;
      default:   slot_legal = 1'b0;
    endcase
  end

  assign scan_bad = (scan_q != 6'd0) && !slot_legal;

  // dp=1 never matches a table entry, so it falls into the code error path
  always_comb begin
    code_ok  = 1'b1;
    code_val = 4'hF;
    case (dout_q)
      8'h3F:   code_val = 4'h0;
      8'h06:   code_val = 4'h1;
      8'h5B:   code_val = 4'h2;
      8'h4F:   code_val = 4'h3;
      8'h66:   code_val = 4'h4;
      8'h6D:   code_val = 4'h5;
      8'h7D:   code_val = 4'h6;
      8'h07:   code_val = 4'h7;
      8'h7F:   code_val = 4'h8;
      8'h6F:   code_val = 4'h9;
      8'h77:   code_val = 4'hA;
      8'h7C:   code_val = 4'hB;
      8'h39:   code_val = 4'hC;
      8'h5E:   code_val = 4'hD;
      8'h79:   code_val = 4'hE;
      8'h00:   code_val = 4'hF;
      default: code_ok  = 1'b0;
    endcase
  end

  always_comb begin
    digit_d    = digit_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    vld_d      = vld_q;
    state_d    = state_q;
    idle_d     = idle_q;
    stale_d    = stale_q;
    frame_d    = 1'b0;
    scan_err_d = scan_bad;
    code_err_d = 1'b0;
    seq_err_d  = 1'b0;
    next_cnt   = 2'd0;

    if (slot_legal) begin
      idle_d  = 8'd0;
      stale_d = 1'b0;

      // A count of zero means there is no trusted previous visit to compare with
      if (!code_ok) begin
        code_err_d  = 1'b1;
        cnt_d[slot] = 2'd0;
      end else begin
        if ((cnt_q[slot] != 2'd0) && (last_q[slot] == code_val)) begin
          next_cnt = (cnt_q[slot] >= STABLE_L) ? STABLE_L : cnt_q[slot] + 2'd1;
        end else begin
          next_cnt = 2'd1;
        end
        cnt_d[slot]  = next_cnt;
        last_d[slot] = code_val;
        if (next_cnt == STABLE_L) begin
          digit_d[slot] = code_val;
          vld_d[slot]   = 1'b1;
        end
      end

      if (slot == 2'd0) begin
        state_d = ST_SEEN0;
      end else begin
        case (state_q)
          ST_SEEN0: begin
            if (slot == 2'd1) state_d = ST_SEEN1;
            else begin state_d = ST_WAIT0; seq_err_d = 1'b1; end
          end
          ST_SEEN1: begin
            if (slot == 2'd1) state_d = ST_SEEN1;
            else if (slot == 2'd2) state_d = ST_SEEN2;
            else begin state_d = ST_WAIT0; seq_err_d = 1'b1; end
          end
          ST_SEEN2: begin
            if (slot == 2'd2) state_d = ST_SEEN2;
            else if (slot == 2'd3) begin
              state_d = ST_WAIT0;
              frame_d = &vld_d;
            end else begin state_d = ST_WAIT0; seq_err_d = 1'b1; end
          end
          default: begin
            state_d   = ST_WAIT0;
            seq_err_d = 1'b1;
          end
        endcase
      end
    end else begin
      if (idle_q != TIMEOUT_L) idle_d = idle_q + 8'd1;
      if (idle_d == TIMEOUT_L) begin
        stale_d = 1'b1;
        vld_d   = 4'd0;
        cnt_d   = '0;
        state_d = ST_WAIT0;
      end
    end
  end

  always_ff @(posedge clk1khz) begin
    if (!rst) begin
      scan_q     <= 6'd0;
      dout_q     <= 8'd0;
      digit_q    <= {4{4'hF}};
      last_q     <= '0;
      cnt_q      <= '0;
      vld_q      <= 4'd0;
      state_q    <= ST_WAIT0;
      idle_q     <= 8'd0;
      stale_q    <= 1'b0;
      frame_q    <= 1'b0;
      scan_err_q <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      scan_q     <= scan;
      dout_q     <= dout;
      digit_q    <= digit_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      state_q    <= state_d;
      idle_q     <= idle_d;
      stale_q    <= stale_d;
      frame_q    <= frame_d;
      scan_err_q <= scan_err_d;
      code_err_q <= code_err_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign digit0     = digit_q[0];
  assign digit1     = digit_q[1];
  assign digit2     = digit_q[2];
  assign digit3     = digit_q[3];
  assign digit_vld  = vld_q;
  assign frame_done = frame_q;
  assign scan_err   = scan_err_q;
  assign code_err   = code_err_q;
  assign seq_err    = seq_err_q;
  assign stale      = stale_q;

`ifdef SEG_PAIR_VALUE_EN
  logic [6:0] val_a_q, val_b_q;

  function automatic logic [6:0] pair_val(input logic [3:0] hi, input logic [3:0] lo);
    if ((hi > 4'd9) || (lo > 4'd9)) return 7'h7F;
    return ({3'b000, hi} * 7'd10) + {3'b000, lo};
  endfunction

  // Built from the registered digits, so these trail a digit update by one edge
  always_ff @(posedge clk1khz) begin
    if (!rst) begin
      val_a_q <= 7'h7F;
      val_b_q <= 7'h7F;
    end else begin
      val_a_q <= pair_val(digit_q[1], digit_q[0]);
      val_b_q <= pair_val(digit_q[3], digit_q[2]);
    end
  end

  assign val_a = val_a_q;
  assign val_b = val_b_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int STABLE = 2;
  localparam int TMO    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] scan = 6'd0;
  logic [7:0] dout = 8'd0;
  logic [3:0] d0, d1, d2, d3, vld;
  logic       fd, se, ce, qe, st;
`ifdef SEG_PAIR_VALUE_EN
  logic [6:0] va, vb;
`endif

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CNT(STABLE), .TIMEOUT(TMO)) dut (
    .clk1khz   (clk),
    .rst       (rst),
    .scan      (scan),
    .dout      (dout),
    .digit0    (d0),
    .digit1    (d1),
    .digit2    (d2),
    .digit3    (d3),
    .digit_vld (vld),
    .frame_done(fd),
    .scan_err  (se),
    .code_err  (ce),
    .seq_err   (qe),
`ifdef SEG_PAIR_VALUE_EN
    .val_a     (va),
    .val_b     (vb),
`endif
    .stale     (st)
  );

  typedef struct {
    int          due;
    logic [15:0] digits;
    logic [3:0]  vld;
    logic [3:0]  pulses;
    logic        stale;
    logic [13:0] vals;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] codes [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};

  int         m_digit [4];
  int         m_vld [4];
  int         m_cnt [4];
  int         m_last [4];
  int         m_seq;
  int         m_idle;
  bit         m_stale, m_fd, m_se, m_ce, m_qe;
  logic [6:0] m_va, m_vb;
  logic [5:0] p_scan;
  logic [7:0] p_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, expv);
    end
  endtask

  function automatic int slot_of(input logic [5:0] s);
    if (s == 6'b000001) return 0;
    if (s == 6'b000010) return 1;
    if (s == 6'b010000) return 2;
    if (s == 6'b100000) return 3;
    if (s == 6'd0) return -1;
    return -2;
  endfunction

  function automatic logic [5:0] pat(input int sl);
    case (sl)
      0: return 6'b000001;
      1: return 6'b000010;
      2: return 6'b010000;
      default: return 6'b100000;
    endcase
  endfunction

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 16; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [6:0] pv(input int hi, input int lo);
    if (hi > 9 || lo > 9) return 7'h7F;
    return 7'(hi * 10 + lo);
  endfunction

  // One rising edge of the reference: reset, or consume the previously latched sample
  task automatic model_step(input logic r, input logic [5:0] s, input logic [7:0] d);
    int   sl, v;
    bit   all;
    exp_t e;
    m_fd = 0; m_se = 0; m_ce = 0; m_qe = 0;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_digit[i] = 15; m_vld[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
      end
      m_seq = 0; m_idle = 0; m_stale = 0;
      p_scan = 6'd0; p_dout = 8'd0;
      m_va = 7'h7F; m_vb = 7'h7F;
    end else begin
      m_va = pv(m_digit[1], m_digit[0]);
      m_vb = pv(m_digit[3], m_digit[2]);
      sl = slot_of(p_scan);
      if (sl >= 0) begin
        m_idle = 0; m_stale = 0;
        v = lookup(p_dout);
        if (v < 0) begin
          m_ce = 1; m_cnt[sl] = 0;
        end else begin
          if (m_cnt[sl] > 0 && m_last[sl] == v)
            m_cnt[sl] = (m_cnt[sl] + 1 > STABLE) ? STABLE : m_cnt[sl] + 1;
          else
            m_cnt[sl] = 1;
          m_last[sl] = v;
          if (m_cnt[sl] == STABLE) begin m_digit[sl] = v; m_vld[sl] = 1; end
        end
        if (sl == 0) m_seq = 1;
        else if (m_seq > 0 && sl == m_seq - 1) m_seq = m_seq;
        else if (m_seq > 0 && sl == m_seq) begin
          if (sl == 3) begin
            m_seq = 0;
            all = 1;
            for (int i = 0; i < 4; i++) if (m_vld[i] == 0) all = 0;
            m_fd = all;
          end else m_seq = sl + 1;
        end else begin
          m_qe = 1; m_seq = 0;
        end
      end else begin
        if (sl == -2) m_se = 1;
        if (m_idle < TMO) m_idle++;
        if (m_idle == TMO) begin
          m_stale = 1; m_seq = 0;
          for (int i = 0; i < 4; i++) begin m_vld[i] = 0; m_cnt[i] = 0; end
        end
      end
      p_scan = s; p_dout = d;
    end
    e.due    = cyc + 1;
    e.digits = {4'(m_digit[3]), 4'(m_digit[2]), 4'(m_digit[1]), 4'(m_digit[0])};
    e.vld    = {m_vld[3] != 0, m_vld[2] != 0, m_vld[1] != 0, m_vld[0] != 0};
    e.pulses = {m_fd, m_se, m_ce, m_qe};
    e.stale  = m_stale;
    e.vals   = {m_va, m_vb};
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [5:0] s, input logic [7:0] d);
    @(negedge clk);
    rst = r; scan = s; dout = d;
    model_step(r, s, d);
  endtask

  task automatic visit(input int sl, input int val);
    drive(1'b1, pat(sl), codes[val]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due != cyc) chk("schedule", 32'(e.due), 32'(cyc));
        chk("digits", {16'd0, d3, d2, d1, d0}, {16'd0, e.digits});
        chk("digit_vld", {28'd0, vld}, {28'd0, e.vld});
        chk("pulses{frame,scan,code,seq}", {28'd0, fd, se, ce, qe}, {28'd0, e.pulses});
        chk("stale", {31'd0, st}, {31'd0, e.stale});
`ifdef SEG_PAIR_VALUE_EN
        chk("val_a_b", {18'd0, va, vb}, {18'd0, e.vals});
`endif
      end
    end
  end

  initial begin : stim
    int r, sl, nxt;
    int want [4];
    logic [7:0] code;
    repeat (3) drive(1'b0, 6'd0, 8'd0);

    repeat (2) begin
      visit(0, 0); visit(1, 2); visit(2, 4); visit(3, 1);
    end
    drive(1'b1, 6'b000100, 8'h3F);
    drive(1'b1, 6'b000011, 8'h3F);
    drive(1'b1, 6'd0, 8'h3F);

    visit(1, 13); visit(1, 15); visit(1, 13); visit(1, 13);
    drive(1'b1, pat(1), 8'h80);
    drive(1'b1, pat(1), 8'h12);

    visit(0, 0); visit(2, 4);
    visit(3, 1);
    visit(0, 0); visit(1, 2); visit(2, 4); visit(3, 1);

    visit(0, 0); visit(1, 2);
    drive(1'b0, pat(2), codes[4]);
    visit(2, 4); visit(3, 1);
    visit(0, 0); visit(1, 2); visit(2, 4); visit(3, 1);

    repeat (TMO + 5) drive(1'b1, 6'd0, 8'd0);
    visit(0, 0);
    drive(1'b1, 6'd0, 8'd0);

    repeat (2) begin
      visit(0, 9); visit(1, 2); visit(2, 0); visit(3, 4);
    end
    drive(1'b1, 6'd0, 8'd0);
    visit(0, 13); visit(0, 13);
    repeat (3) drive(1'b1, 6'd0, 8'd0);

    nxt = 0;
    for (int i = 0; i < 4; i++) want[i] = $urandom_range(0, 15);
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        sl = nxt;
        nxt = (nxt + 1) % 4;
        if ($urandom_range(0, 4) == 0) want[sl] = $urandom_range(0, 15);
        code = ($urandom_range(0, 19) == 0) ? 8'($urandom) : codes[want[sl]];
        drive(1'b1, pat(sl), code);
      end else if (r < 75) begin
        drive(1'b1, pat($urandom_range(0, 3)), codes[$urandom_range(0, 15)]);
      end else if (r < 85) begin
        drive(1'b1, 6'd0, 8'($urandom));
      end else if (r < 96) begin
        drive(1'b1, 6'($urandom), 8'($urandom));
      end else if (r < 97) begin
        drive(1'b0, 6'($urandom), 8'($urandom));
        nxt = 0;
      end else begin
        visit(0, want[0]);
        nxt = 1;
      end
    end

    repeat (TMO + 3) drive(1'b1, (($urandom_range(0, 3) == 0) ? 6'b001100 : 6'd0), 8'($urandom));
    visit(3, 3);
    repeat (4) drive(1'b1, 6'd0, 8'd0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
